// File: rtl/multiplicador_8bits_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//
// Holds the FSM state encoding, the iteration bound and the product width,
// plus a helper that gates the multiplicand onto the adder's second operand.
package multiplicador_8bits_pkg;

    // The only legal operand width; it matches the ripple-carry adder.
    localparam int unsigned OPER_W = 8;

    // Product width: twice the operand width.
    localparam int unsigned PROD_W = 16;

    // count value during the last CALC cycle.
    localparam logic [2:0] ITER_LAST = 3'd7;

    // 2-bit state encoding. Code 2'd3 is unused and is treated as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Selects the partial product for one iteration: M when the current
    // multiplier bit is set, zero otherwise.
    function automatic logic [OPER_W-1:0] partial_operand(
        input logic              sel,
        input logic [OPER_W-1:0] m
    );
        return sel ? m : '0;
    endfunction

endpackage

// File: rtl/somador8bits.sv
// 8-bit ripple-carry adder.
//
// Ports:
//   a    in   8  first operand
//   b    in   8  second operand
//   cin  in   1  carry in
//   s    out  8  sum
//   cout out  1  carry out of the most significant bit
module somador8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    // carry[i] is the carry into bit i; carry[8] is the final carry out.
    logic [8:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[8];

endmodule

// File: rtl/multiplicador_8bits.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
//
// A product takes a fixed 8 CALC cycles followed by one DONE cycle. Each CALC
// cycle adds the multiplicand (or zero) to the high half and shifts the
// 17-bit {carry, sum, low half} right by one. The only adder is somador8bits.
//
// Ports:
//   clk   in   1   system clock, rising edge
//   rst   in   1   synchronous active-high reset
//   start in   1   request pulse, honoured only in IDLE
//   A     in   8   multiplicand, sampled on the accepting edge
//   B     in   8   multiplier, sampled on the accepting edge
//   busy  out  1   high in CALC and DONE
//   done  out  1   one-cycle pulse, P valid
//   P     out  16  product A*B; held until the next DONE or reset
module multiplicador_8bits
    import multiplicador_8bits_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    // The datapath is tied to the 8-bit adder; any other width is rejected.
    if (WIDTH != OPER_W) begin : g_width_check
        $error("multiplicador_8bits: WIDTH must be 8");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [2:0]        count_q, count_d;
    logic [PROD_W-1:0] p_q, p_d;

    logic [WIDTH-1:0]  add_b;
    logic [WIDTH-1:0]  add_s;
    logic              add_cout;

    assign add_b = partial_operand(q_q[0], m_q);

    somador8bits u_somador (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        count_d = count_q;
        p_d     = p_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Right shift of {cout, sum, Q}: cout lands in ACC[7] and the
                // consumed multiplier bit drops off Q[0].
                {acc_d, q_d} = {add_cout, add_s, q_q[WIDTH-1:1]};
                count_d      = count_q + 3'd1;
                if (count_q == ITER_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                p_d     = {acc_q, q_q};
                state_d = ST_IDLE;
            end
            default: begin
                // Unused code: fall back to IDLE, leave all registers alone.
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs. P shows the live result during DONE so it is valid with done.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        P    = p_q;
        unique case (state_q)
            ST_CALC: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
                P    = {acc_q, q_q};
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            count_q <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            count_q <= count_d;
            p_q     <= p_d;
        end
    end

endmodule

// File: tb/tb_multiplicador_8bits.sv
// Self-checking bench for multiplicador_8bits: directed scenarios followed by
// randomized traffic, compared each cycle against a transaction-level model.
module tb_multiplicador_8bits;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] P;

    int n_checks;
    int n_fail;
    int n_done;

    // Reference model: cycles since the accepting edge (0 = idle), the pending
    // product and the held product.
    int          mdl_phase;
    logic [15:0] mdl_pend;
    logic [15:0] mdl_p;

    multiplicador_8bits #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance model and DUT by one edge, compare.
    task automatic cycle(input logic r, input logic s, input logic [7:0] av,
                         input logic [7:0] bv);
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_p;
        rst   = r;
        start = s;
        a     = av;
        b     = bv;
        @(posedge clk);
        if (r) begin
            mdl_phase = 0;
            mdl_p     = 16'h0000;
        end else if (mdl_phase == 0) begin
            if (s) begin
                mdl_pend  = 16'(av) * 16'(bv);
                mdl_phase = 1;
            end
        end else if (mdl_phase < 9) begin
            mdl_phase++;
        end else begin
            mdl_p     = mdl_pend;
            mdl_phase = 0;
        end
        e_busy = (mdl_phase != 0);
        e_done = (mdl_phase == 9);
        e_p    = e_done ? mdl_pend : mdl_p;
        #1;
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("P", 32'(P), 32'(e_p));
        if (done === 1'b1) n_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    initial begin
        int d0;
        n_checks  = 0;
        n_fail    = 0;
        n_done    = 0;
        mdl_phase = 0;
        mdl_pend  = 16'h0000;
        mdl_p     = 16'h0000;
        rst       = 1'b1;
        start     = 1'b0;
        a         = 8'h00;
        b         = 8'h00;

        // Reset then idle.
        cycle(1'b1, 1'b0, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 8'h00, 8'h00);
        idle(5);
        check("reset_p", 32'(P), 32'h0000);

        // Basic: 13 * 11, single done, result held afterwards.
        d0 = n_done;
        cycle(1'b0, 1'b1, 8'd13, 8'd11);
        idle(8);
        check("basic_done_at_9", 32'(done), 32'd1);
        check("basic_p", 32'(P), 32'h008F);
        idle(4);
        check("basic_once", 32'(n_done - d0), 32'd1);
        check("basic_hold", 32'(P), 32'h008F);

        // Extremes.
        cycle(1'b0, 1'b1, 8'hFF, 8'hFF);
        idle(8);
        check("max_p", 32'(P), 32'hFE01);
        idle(1);
        cycle(1'b0, 1'b1, 8'h00, 8'h5A);
        idle(7);
        check("zero_not_early", 32'(done), 32'd0);
        idle(1);
        check("zero_done", 32'(done), 32'd1);
        check("zero_p", 32'(P), 32'h0000);
        idle(1);

        // Start during busy is ignored.
        d0 = n_done;
        cycle(1'b0, 1'b1, 8'h10, 8'h10);
        idle(3);
        cycle(1'b0, 1'b1, 8'h03, 8'h03);
        idle(10);
        check("busy_start_once", 32'(n_done - d0), 32'd1);
        check("busy_start_p", 32'(P), 32'h0100);

        // Reset mid-operation discards the result.
        d0 = n_done;
        cycle(1'b0, 1'b1, 8'hAA, 8'h55);
        idle(4);
        cycle(1'b1, 1'b0, 8'hAA, 8'h55);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_p", 32'(P), 32'h0000);
        idle(12);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        cycle(1'b0, 1'b1, 8'h02, 8'h03);
        idle(8);
        check("after_rst_p", 32'(P), 32'h0006);
        idle(1);

        // Back-to-back: start held high.
        d0 = n_done;
        for (int i = 0; i < 31; i++) cycle(1'b0, 1'b1, 8'h07, 8'h09);
        check("b2b_count", 32'(n_done - d0), 32'd3);
        check("b2b_p", 32'(P), 32'h003F);
        idle(10);

        // Randomized traffic with occasional resets and busy-time starts.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 80) == 0), 1'($urandom_range(0, 2) == 0),
                  8'($urandom), 8'($urandom));
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplicador_8bits.md
Name: multiplicador_8bits

Overview:
- Sequential 8x8 unsigned shift-and-add multiplier.
- Built directly around the existing 8-bit ripple-carry adder: it feeds the adder's operands each cycle and consumes its sum and carry-out.
- Produces a 16-bit product in a fixed 8 iterations.
- Used by the datapath wherever a product is needed without a combinational array multiplier.

Parameters:
- WIDTH, 8, operand width. Fixed at 8 to match somador8bits. Any other value is illegal; a synthesis-time check shall reject it.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  8  multiplicand; sampled on the accepted start edge.
- B  input  8  multiplier; sampled on the accepted start edge.
- busy  output  1  high while in CALC or DONE.
- done  output  1  one-cycle pulse; product valid.
- P  output  16  unsigned product A*B.

Behaviour:
- Reset: rst=1 at a rising edge forces state=IDLE, busy=0, done=0, P=0, and internal M, ACC, Q, count = 0. Reset takes priority over every other input, including mid-operation; any in-flight result is discarded.
- Registers:
  - M (8b): latched multiplicand.
  - ACC (8b): partial high half.
  - Q (8b): multiplier / low half.
  - count (3b).
- Adder hookup: somador8bits instance with inputs ACC, (Q[0] ? M : 8'h00), Cin=0. Its outputs are S and Cout.
- IDLE:
  - busy=0.
  - On start=1: M<=A, Q<=B, ACC<=0, count<=0, go to CALC.
  - A and B are ignored otherwise.
- CALC (exactly 8 cycles):
  - Each edge: {ACC,Q} <= {Cout, S, Q[7:1]}, i.e. a 17-bit right shift of {Cout,S,Q}.
  - count <= count+1.
  - When count==7 at the edge, go to DONE.
- DONE (exactly 1 cycle):
  - done=1, busy=1.
  - Next edge: P <= {ACC,Q} captured at entry, go to IDLE.
  - P shall be driven with {ACC,Q} combinationally in DONE, so P is valid while done=1. P then holds that value until the next accepted start's DONE or reset.
- Latency: start sampled at edge t gives CALC for edges t+1..t+8, done=1 during the cycle after edge t+8, and a new start is accepted at edge t+10 at the earliest. Throughput is 1 product per 10 cycles.
- start while busy (CALC or DONE): ignored; there is no queuing. A and B may change freely after the accepting edge.
- Overflow: impossible. The maximum 0xFF*0xFF = 0xFE01 fits in 16 bits. Cout is always absorbed into ACC[7] via the shift.
- Operands of 0: the full 8 cycles still run; there is no early termination.
- The state encoding is 2-bit. The unused code maps to IDLE with all registers unchanged.

Decomposition:
- Shared header (`define include, e.g. mult_defs.vh) holds:
  - state codes ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2
  - ITER_LAST=3'd7
  - PROD_W=16
- Sub-module: reuse the existing somador8bits as the sole datapath adder, instantiated once. No new sub-module is needed.
- FSM and shift register stay in this module.

Test Plan:
- Reset then idle: hold rst 2 cycles, start=0 -> busy=0, done=0, P=16'h0000 for 5 cycles.
- Basic: A=8'd13, B=8'd11, 1-cycle start -> busy=1 for 9 cycles, done=1 exactly once 9 cycles after start edge, P=16'h008F. P holds 16'h008F afterwards.
- Extremes: A=8'hFF, B=8'hFF -> P=16'hFE01. Then A=8'h00, B=8'h5A -> P=16'h0000, still after the full 9-cycle latency.
- Start during busy: start with A=8'h10, B=8'h10, then pulse start with A=8'h03, B=8'h03 at cycle 4 -> single done, P=16'h0100, second request ignored.
- Reset mid-operation: start A=8'hAA, B=8'h55, assert rst at CALC cycle 5 -> next cycle busy=0, done=0, P=0. No done pulse follows. A new start with A=8'h02, B=8'h03 yields P=16'h0006.
- Back-to-back: start held high continuously with A=8'h07, B=8'h09 -> a done pulse every 10 cycles, each with P=16'h003F.
